trig_emulator: RTL and testbench

TRIG_EMULATOR -- requirements
Module: trig_emulator

---
 rtl/trig_emulator.sv | 120 ++++++++++++
 tb/tb_trig_emulator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/trig_emulator.sv
// rtl/trig_emulator.sv - emulated spill/trigger pattern generator; TRIGEMU_RANDOM_EN adds LFSR jitter to GAP
module trig_emulator #(
    parameter int PULSEW = 4,
    parameter int CYCLEW = 320,
    parameter int MINGAP = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] period,
    input  logic [15:0] nburst,
    input  logic        cyclereq,
    output logic        trigemu,
    output logic        busy,
    output logic [15:0] spillcnt,
    output logic [15:0] trigcnt
);

    typedef enum logic [2:0] {IDLE, CYCLE, CGAP, PULSE, GAP} state_t;

    state_t      state;
    state_t      next_state;
    logic [16:0] timer;
    logic [16:0] load_val;
    logic [15:0] period_l;
    logic [15:0] nburst_l;
    logic        pending;
    logic [15:0] gap_g;
    logic [16:0] gap_len;

    assign gap_g = (period_l > 16'(MINGAP)) ? period_l : 16'(MINGAP);
    assign busy  = (state != IDLE);

`ifdef TRIGEMU_RANDOM_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign gap_len = {1'b0, gap_g} + {11'd0, lfsr[5:0]};
`else
    assign gap_len = {1'b0, gap_g};
`endif

    // A cyclereq arriving on the last GAP clock still redirects to CYCLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (enable) next_state = CYCLE;
            CYCLE: if (timer == 17'd0) next_state = CGAP;
            CGAP: begin
                if (timer == 17'd0) begin
                    if (nburst_l != 16'd0) next_state = PULSE;
                    else                   next_state = enable ? CYCLE : IDLE;
                end
            end
            PULSE: if (timer == 17'd0) next_state = GAP;
            GAP: begin
                if (timer == 17'd0) begin
                    if (!enable)
                        next_state = IDLE;
                    else if (trigcnt == nburst_l || pending || cyclereq)
                        next_state = CYCLE;
                    else
                        next_state = PULSE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_val = 17'd0;
        case (next_state)
            CYCLE:   load_val = 17'(CYCLEW - 1);
            CGAP:    load_val = {1'b0, gap_g} - 17'd1;
            PULSE:   load_val = 17'(PULSEW - 1);
            GAP:     load_val = gap_len - 17'd1;
            default: load_val = 17'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= 17'd0;
            trigemu  <= 1'b0;
            spillcnt <= 16'd0;
            trigcnt  <= 16'd0;
            pending  <= 1'b0;
            period_l <= 16'd0;
            nburst_l <= 16'd0;
        end else begin
            state   <= next_state;
            trigemu <= (state == CYCLE) || (state == PULSE);
            if (cyclereq && state != IDLE) pending <= 1'b1;
            if (next_state != state) begin
                timer <= load_val;
                if (next_state == CYCLE) begin
                    period_l <= period;
                    nburst_l <= nburst;
                    pending  <= 1'b0;
                end
                if (state == CYCLE) begin
                    spillcnt <= spillcnt + 16'd1;
                    trigcnt  <= 16'd0;
                end
                if (state == PULSE && trigcnt != 16'hFFFF) trigcnt <= trigcnt + 16'd1;
            end else if (timer != 17'd0) begin
                timer <= timer - 17'd1;
            end
        end
    end

endmodule

// File: tb/tb_trig_emulator.sv
// tb/tb_trig_emulator.sv - self-checking bench for trig_emulator using a segment-level waveform model
`timescale 1ns/1ps
module tb_trig_emulator;

    localparam int CW = 320;
    localparam int PW = 4;
    localparam int MG = 64;
`ifdef TRIGEMU_RANDOM_EN
    localparam int GE = 63;
`else
    localparam int GE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] period;
    logic [15:0] nburst;
    logic        cyclereq;
    logic        trigemu;
    logic        busy;
    logic [15:0] spillcnt;
    logic [15:0] trigcnt;

    int tests = 0;
    int fails = 0;
    int exp_spill = 0;

    always #3.125 clk = ~clk;

    trig_emulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .period   (period),
        .nburst   (nburst),
        .cyclereq (cyclereq),
        .trigemu  (trigemu),
        .busy     (busy),
        .spillcnt (spillcnt),
        .trigcnt  (trigcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic int gmax(input int p);
        return (p > MG) ? p : MG;
    endfunction

    // Called on the first sample of a level; returns on the first sample of the next level.
    task automatic seg(input logic lvl, input int lo, input int hi, input string tag);
        int cnt = 0;
        while (trigemu === lvl && cnt <= hi) begin
            cnt++;
            @(negedge clk);
        end
        if (lo == hi) chk(tag, cnt, lo);
        else          chk_rng(tag, cnt, lo, hi);
    endtask

    task automatic wait_high(input string tag);
        int cnt = 0;
        while (trigemu !== 1'b1 && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk(tag, {31'd0, trigemu}, 1);
    endtask

    // Expected waveform of one spill from its latched settings; new settings are applied mid-spill.
    task automatic run_spill(input int p, input int n, input int np, input int nn);
        int g = gmax(p);
        period = 16'(np);
        nburst = 16'(nn);
        seg(1'b1, CW, CW, "cycle_high");
        exp_spill++;
        chk("spillcnt", spillcnt, exp_spill);
        chk("trigcnt_clear", trigcnt, 0);
        seg(1'b0, g, g, "cgap_low");
        for (int i = 1; i <= n; i++) begin
            seg(1'b1, PW, PW, "pulse_high");
            chk("trigcnt", trigcnt, i);
            seg(1'b0, g, g + GE, "gap_low");
        end
    endtask

    initial begin
        int cur_p;
        int cur_n;
        int np;
        int nn;
        int cnt;

        rst_n    = 1'b0;
        enable   = 1'b0;
        period   = 16'd100;
        nburst   = 16'd3;
        cyclereq = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trigemu", {31'd0, trigemu}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_spillcnt", spillcnt, 0);
        chk("rst_trigcnt", trigcnt, 0);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_enable", {31'd0, busy}, 0);

        enable = 1'b1;
        @(negedge clk);
        chk("start_busy", {31'd0, busy}, 1);
        chk("start_latency", {31'd0, trigemu}, 0);
        @(negedge clk);
        chk("start_high", {31'd0, trigemu}, 1);

        run_spill(100, 3, 100, 3);
        run_spill(100, 3, 10, 2);
        run_spill(10, 2, 100, 3);

        // enable dropped during the second short pulse
        seg(1'b1, CW, CW, "drop_cycle");
        exp_spill++;
        chk("drop_spillcnt", spillcnt, exp_spill);
        seg(1'b0, 100, 100, "drop_cgap");
        seg(1'b1, PW, PW, "drop_p1");
        seg(1'b0, 100, 100 + GE, "drop_gap1");
        enable = 1'b0;
        seg(1'b1, PW, PW, "drop_p2");
`ifdef TRIGEMU_RANDOM_EN
        cnt = 0;
        while (busy !== 1'b0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk_rng("drop_gap_len", cnt + 1, 100, 163);
`else
        repeat (98) @(negedge clk);
        chk("drop_busy_last_gap", {31'd0, busy}, 1);
        @(negedge clk);
`endif
        chk("drop_busy_idle", {31'd0, busy}, 0);
        chk("drop_trigemu_idle", {31'd0, trigemu}, 0);
        repeat (10) @(negedge clk);
        chk("idle_stays_low", {31'd0, trigemu}, 0);

        // cyclereq in IDLE ignored, then cyclereq during the first GAP
        period   = 16'd100;
        nburst   = 16'd10;
        cyclereq = 1'b1;
        @(negedge clk);
        cyclereq = 1'b0;
        chk("idle_cyclereq", {31'd0, busy}, 0);
        enable = 1'b1;
        wait_high("req_rise");
        seg(1'b1, CW, CW, "req_cycle");
        exp_spill++;
        chk("req_spillcnt", spillcnt, exp_spill);
        seg(1'b0, 100, 100, "req_cgap");
        seg(1'b1, PW, PW, "req_p1");
        chk("req_trigcnt_p1", trigcnt, 1);
        cyclereq = 1'b1;
        @(negedge clk);
        cyclereq = 1'b0;
        seg(1'b0, 99, 99 + GE, "req_gap");
        chk("req_trigcnt_pre", trigcnt, 1);
        period = 16'd64;
        nburst = 16'd1;
        seg(1'b1, CW, CW, "req_cycle2");
        exp_spill++;
        chk("req_spillcnt2", spillcnt, exp_spill);
        chk("req_trigcnt_post", trigcnt, 0);
        seg(1'b0, 100, 100, "req_cgap2");
        seg(1'b1, PW, PW, "req_pending_cleared");

        // reset mid-GAP, then reset for one clock in the middle of CYCLE
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_gap_spillcnt", spillcnt, 0);
        exp_spill = 0;
        wait_high("rst_rise");
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_trigemu", {31'd0, trigemu}, 0);
        chk("rst_mid_spillcnt", spillcnt, 0);
        chk("rst_mid_busy", {31'd0, busy}, 0);
        chk("rst_mid_trigcnt", trigcnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_restart_busy", {31'd0, busy}, 1);
        chk("rst_restart_latency", {31'd0, trigemu}, 0);
        @(negedge clk);
        chk("rst_restart_high", {31'd0, trigemu}, 1);

        cur_p = 64;
        cur_n = 1;
        for (int k = 0; k < 5; k++) begin
            np = $urandom_range(0, 140);
            nn = $urandom_range(0, 3);
            run_spill(cur_p, cur_n, np, nn);
            cur_p = np;
            cur_n = nn;
        end

        enable = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
